// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
//
// Multi-channel glitch-free clock gating controller. Each channel owns an idle
// counter that gates its clock after IDLE_CYCLES consecutive idle cycles, and a
// RUN / GATED / WAKE state machine that restores the clock on demand and
// reports when the gated clock is stable again.
//
// Gate cell per channel: a posedge enable flop (en_q) OR scan_enable feeds a
// latch that is transparent while clk is low; gclk = clk AND latch. The enable
// can therefore only change while clk is low, so gclk never glitches and never
// produces a truncated high pulse.
//
// Optional feature macro: CLK_GATE_STATS_EN
//   defined   -> per-channel saturating gated-cycle counters on gated_cnt
//   undefined -> gated_cnt port and counters are absent
//
// Parameters:
//   N            number of gated channels (1..32)
//   IDLE_CYCLES  consecutive idle cycles before a channel gates (1..2^CNT_W-1)
//   WAKE_CYCLES  settle cycles spent in WAKE before clk_ready (0 = skip WAKE)
//   CNT_W        width of the idle, wake and statistics counters
//
// Ports:
//   clk          root clock
//   rst_n        asynchronous active-low reset
//   scan_enable  forces every gclk to follow clk; FSMs are unaffected
//   auto_en[N]   per-channel auto-gating enable (0 = channel never gates)
//   force_on[N]  per-channel override, holds or returns the channel to RUN
//   busy[N]      channel activity (1 = not idle)
//   wake_req[N]  clock request, held high while the clock is in use
//   clk_ready[N] 1 = channel in RUN, gclk stable
//   gated[N]     1 = channel in GATED
//   gclk[N]      gated clocks
//   gated_cnt    per-channel gated-cycle counters, channel i at
//                [i*CNT_W +: CNT_W] (CLK_GATE_STATS_EN only)
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
    parameter int N           = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_enable,
    input  logic [N-1:0]       auto_en,
    input  logic [N-1:0]       force_on,
    input  logic [N-1:0]       busy,
    input  logic [N-1:0]       wake_req,
    output logic [N-1:0]       clk_ready,
    output logic [N-1:0]       gated,
    output logic [N-1:0]       gclk
`ifdef CLK_GATE_STATS_EN
    ,
    output logic [N*CNT_W-1:0] gated_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_e;

    // Terminal counts. The idle counter is compared against IDLE_CYCLES-1 so
    // that the increment "to IDLE_CYCLES" and the move to GATED share one edge.
    localparam int             WAKE_LAST_I = (WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_LAST_I);
    localparam bit             SKIP_WAKE   = (WAKE_CYCLES == 0);

    for (genvar g = 0; g < N; g++) begin : g_ch

        state_e           state_q;
        logic [CNT_W-1:0] idle_cnt_q;
        logic [CNT_W-1:0] wake_cnt_q;
        logic             en_q;
        logic             ready_q;
        logic             gated_q;
        logic             latch_en_q;
        logic             ka;

        // Keep-alive: any reason for the channel to keep (or regain) its clock.
        assign ka = busy[g] | wake_req[g] | force_on[g] | ~auto_en[g];

        // Channel FSM with registered status outputs. ka is sampled on the root
        // clock so a gated channel can still notice a request.
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= ST_RUN;
                idle_cnt_q <= '0;
                wake_cnt_q <= '0;
                en_q       <= 1'b1;
                ready_q    <= 1'b1;
                gated_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        // ka has priority over the terminal count: a request
                        // arriving on the gating edge cancels the gating.
                        if (ka) begin
                            idle_cnt_q <= '0;
                        end else if (idle_cnt_q == IDLE_LAST) begin
                            idle_cnt_q <= '0;
                            state_q    <= ST_GATED;
                            en_q       <= 1'b0;
                            ready_q    <= 1'b0;
                            gated_q    <= 1'b1;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end

                    ST_GATED: begin
                        if (ka) begin
                            en_q       <= 1'b1;
                            gated_q    <= 1'b0;
                            wake_cnt_q <= '0;
                            idle_cnt_q <= '0;
                            if (SKIP_WAKE) begin
                                state_q <= ST_RUN;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= ST_WAKE;
                            end
                        end
                    end

                    ST_WAKE: begin
                        // Settling is not abortable: a dropped ka here still
                        // lands in RUN, which then restarts idle counting.
                        if (wake_cnt_q == WAKE_LAST) begin
                            wake_cnt_q <= '0;
                            idle_cnt_q <= '0;
                            state_q    <= ST_RUN;
                            ready_q    <= 1'b1;
                        end else begin
                            wake_cnt_q <= wake_cnt_q + 1'b1;
                        end
                    end

                    default: begin
                        state_q    <= ST_RUN;
                        idle_cnt_q <= '0;
                        wake_cnt_q <= '0;
                        en_q       <= 1'b1;
                        ready_q    <= 1'b1;
                        gated_q    <= 1'b0;
                    end
                endcase
            end
        end

        // Gate latch, transparent while clk is low. scan_enable bypasses the
        // FSM enable so test clocks reach every domain.
        // NOTE: this latch is intentional (always_latch); it is what keeps the
        // enable stable through the whole high phase of clk.
        // NOTE: the latch has no reset; during reset en_q is already 1 and the
        // latch picks it up in the next low phase, so the clock resumes there.
        always_latch begin
            if (!clk) begin
                latch_en_q <= en_q | scan_enable;
            end
        end

        assign gclk[g]      = clk & latch_en_q;
        assign clk_ready[g] = ready_q;
        assign gated[g]     = gated_q;

`ifdef CLK_GATE_STATS_EN
        logic [CNT_W-1:0] stat_q;
        logic [CNT_W-1:0] stat_d;

        // Saturating count of cycles spent in GATED; cleared by reset only.
        always_comb begin
            stat_d = stat_q;
            if ((state_q == ST_GATED) && (stat_q != {CNT_W{1'b1}})) begin
                stat_d = stat_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stat_q <= '0;
            end else begin
                stat_q <= stat_d;
            end
        end

        assign gated_cnt[g*CNT_W +: CNT_W] = stat_q;
`endif

    end : g_ch

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_gate_ctrl
//
// Directed, self-checking bench for clk_gate_ctrl with N=4, IDLE_CYCLES=4,
// WAKE_CYCLES=2, CNT_W=8. Inputs change 1 time unit after a rising edge;
// outputs are sampled at the same point (clk high) unless noted, so gclk reads
// back the latched enable for the current high phase.
// Build with +define+CLK_GATE_STATS_EN to include the gated-cycle counters.
// -----------------------------------------------------------------------------
module tb_clk_gate_ctrl;

    localparam int N           = 4;
    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;
    localparam int CNT_W       = 8;

    logic         clk;
    logic         rst_n;
    logic         scan_enable;
    logic [N-1:0] auto_en;
    logic [N-1:0] force_on;
    logic [N-1:0] busy;
    logic [N-1:0] wake_req;
    logic [N-1:0] clk_ready;
    logic [N-1:0] gated;
    logic [N-1:0] gclk;
`ifdef CLK_GATE_STATS_EN
    logic [N*CNT_W-1:0] gated_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    clk_gate_ctrl #(
        .N           (N),
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_enable (scan_enable),
        .auto_en     (auto_en),
        .force_on    (force_on),
        .busy        (busy),
        .wake_req    (wake_req),
        .clk_ready   (clk_ready),
        .gated       (gated),
        .gclk        (gclk)
`ifdef CLK_GATE_STATS_EN
        ,
        .gated_cnt   (gated_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n       = 1'b1;
        scan_enable = 1'b0;
        auto_en     = 4'hF;
        force_on    = 4'h0;
        busy        = 4'h0;
        wake_req    = 4'h0;
        #1 rst_n = 1'b0;

        // ---- reset state -----------------------------------------------------
        step(2);
        check("rst_ready", clk_ready, 4'hF);
        check("rst_gated", gated, 4'h0);
        check("rst_gclk",  gclk, 4'hF);
        rst_n = 1'b1;

        // ---- idle gating: gate on the 4th idle edge --------------------------
        step(1);
        check("rel_ready", clk_ready, 4'hF);
        step(2);
        check("pre_gate", gated, 4'h0);
        step(1);
        check("gate_gated", gated, 4'hF);
        check("gate_ready", clk_ready, 4'h0);
        check("last_pulse", gclk, 4'hF);
        #3;
        check("last_pulse_end", gclk, 4'hF);
        step(1);
        check("gclk_off", gclk, 4'h0);

        // ---- wake handshake on channel 1 -------------------------------------
        wake_req = 4'b0010;
        step(1);
        check("wake_gated", gated, 4'b1101);
        check("wake_gclk0", gclk, 4'h0);
        step(1);
        check("wake_gclk1", gclk, 4'b0010);
        check("wake_mid_ready", clk_ready, 4'h0);
        step(1);
        check("wake_ready", clk_ready, 4'b0010);

        // ---- busy[2] with period 3 never lets channel 2 gate ----------------
        for (int k = 0; k < 30; k++) begin
            busy[2] = (k % 3 == 0);
            step(1);
            check("busy_nogate", {31'd0, gated[2]}, 32'd0);
        end
        check("busy_ready", clk_ready, 4'b0110);

        busy     = 4'h0;
        wake_req = 4'h0;
        step(6);
        check("all_regate", gated, 4'hF);

        // ---- overrides: force_on[0], auto_en[3]=0 ---------------------------
        force_on = 4'b0001;
        auto_en  = 4'b0111;
        step(1);
        check("ovr_wake_gated", gated, 4'b0110);
        check("ovr_wake_ready", clk_ready, 4'h0);
        step(1);
        check("ovr_wake_mid", clk_ready, 4'h0);
        step(1);
        check("ovr_ready", clk_ready, 4'b1001);
        step(10);
        check("ovr_hold_gated", gated, 4'b0110);
        check("ovr_hold_ready", clk_ready, 4'b1001);

        // ---- release; ka rising on the terminal edge beats gating -----------
        force_on = 4'h0;
        auto_en  = 4'hF;
        step(3);
        check("rel3_gated", gated, 4'b0110);
        busy = 4'b0001;
        step(1);
        check("ka_wins", gated, 4'b1110);
        check("ka_wins_ready", clk_ready, 4'b0001);
        busy = 4'h0;
        step(3);
        check("late_pre", gated, 4'b1110);
        step(1);
        check("late_gate", gated, 4'hF);

        // ---- scan_enable overrides gating ------------------------------------
        scan_enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("scan_gclk", gclk, 4'hF);
            check("scan_gated", gated, 4'hF);
        end
        @(negedge clk);
        #1;
        check("scan_low", gclk, 4'h0);
        step(1);
        scan_enable = 1'b0;
        step(1);
        check("scan_off", gclk, 4'h0);

        // ---- reset asserted mid-WAKE on channel 0 ----------------------------
        wake_req = 4'b0001;
        step(1);
        check("pre_rst_gated", gated, 4'b1110);
        check("pre_rst_ready", clk_ready, 4'h0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_ready", clk_ready, 4'hF);
        check("rst_async_gated", gated, 4'h0);
        check("rst_gclk_hold", gclk, 4'h0);
`ifdef CLK_GATE_STATS_EN
        check("rst_stat0", {24'd0, gated_cnt[0 +: CNT_W]}, 32'd0);
`endif
        wake_req = 4'h0;
        step(1);
        check("rst_resume", gclk, 4'hF);
        rst_n = 1'b1;
        step(4);
        check("post_rst_gate", gated, 4'hF);

`ifdef CLK_GATE_STATS_EN
        check("stat_start", {24'd0, gated_cnt[0 +: CNT_W]}, 32'd0);
        step(10);
        check("stat_10", {24'd0, gated_cnt[0 +: CNT_W]}, 32'd10);
        check("stat_10_ch3", {24'd0, gated_cnt[3*CNT_W +: CNT_W]}, 32'd10);
        step(290);
        check("stat_sat", {24'd0, gated_cnt[0 +: CNT_W]}, 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
